mult8_seq: RTL and testbench
============================

MULT8_SEQ -- requirements
Module: mult8_seq

Interface
REQ-001 Parameter: WIDTH, default 8, operand width in bits; product is 2*WIDTH bits.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst_n  input  1  synchronous, active-low reset.
REQ-004 start  input  1  request to begin a multiply; sampled only when in_ready=1.
REQ-005 a  input  WIDTH  multiplicand, unsigned; captured on accept.
REQ-006 b  input  WIDTH  multiplier, unsigned; captured on accept.
REQ-007 in_ready  output  1  high exactly when state=IDLE.
REQ-008 busy  output  1  high exactly when state=RUN.
REQ-009 done  output  1  one-cycle pulse, high exactly when state=DONE.
REQ-010 product  output  2*WIDTH  registered result of the last completed multiply.

Function
REQ-011 The block SHALL use a three-state FSM: IDLE, RUN, DONE.
REQ-012 Accept = start & in_ready at a rising edge; on accept: M<=a, P<={WIDTH'b0, b}, step count<=0, state<=RUN.
REQ-013 start while state is RUN or DONE SHALL be ignored; a and b are not re-sampled.
REQ-014 Each RUN cycle SHALL do one shift-add step: {c, sum} = P[2W-1:W] + (P[0] ? M : 0); P <= {c, sum, P[W-1:1]}; count++.
REQ-015 Step addition SHALL be full WIDTH+1-bit (carry kept); no overflow is possible and no bit is dropped.
REQ-016 After exactly WIDTH RUN steps: state<=DONE and product<=final P, in the same edge.
REQ-017 Latency: accept at edge k gives done=1 in the cycle after edge k+WIDTH (WIDTH+1 cycles accept-to-done at WIDTH=8: done after edge k+8).
REQ-018 DONE SHALL last exactly one cycle and then go to IDLE unconditionally; in_ready rises the cycle after done.
REQ-019 product SHALL hold its value from DONE until the next DONE; it SHALL NOT change during RUN.
REQ-020 Back-to-back: start held high SHALL be accepted on the first IDLE cycle, giving one multiply per WIDTH+2 cycles.

Reset
REQ-021 rst_n=0 at a rising edge SHALL force state=IDLE, P=0, M=0, count=0, product=0; done=0, busy=0, in_ready=1.
REQ-022 Reset during RUN or DONE SHALL abort the operation with no done pulse; product reads 0.
REQ-023 start is ignored at any edge where rst_n=0.

Configuration
REQ-024 Macro MULT8_SEQ_ZERO_SKIP_EN: when defined, an accept with a==0 or b==0 SHALL go directly to DONE at the next edge with product<=0 (done one cycle after accept).
REQ-025 Without MULT8_SEQ_ZERO_SKIP_EN, zero operands SHALL take the full WIDTH-step path, with identical product and timing to REQ-017.

Structure
REQ-026 Package mult8_pkg SHALL hold the FSM state typedef (IDLE, RUN, DONE) and the default WIDTH constant.
REQ-027 The step adder SHALL be a sub-module mult8_step_add: a combinational WIDTH-bit adder with carry-in tied to 0 and carry-out, built from the team's existing full_adder cells.
REQ-028 All other logic (FSM, P/M/count registers, product register) SHALL live in mult8_seq.

Verification (WIDTH=8)
REQ-029 a=0xFF, b=0xFF, one-cycle start -> busy for 8 cycles, done pulse after edge k+8, product=0xFE01.
REQ-030 a=0x0D, b=0x0B -> product=0x008F; a=0x80, b=0x02 -> product=0x0100; done is one cycle wide in both.
REQ-031 a=0x00, b=0x37 -> product=0x0000; done after edge k+1 with the macro defined, after edge k+8 without it.
REQ-032 Accept 0x03*0x05, then pulse start with a=0xAA, b=0xAA mid-RUN -> start ignored, product=0x000F, next accept only after done.
REQ-033 Complete 0x10*0x10=0x0100, start 0xFF*0x02, assert rst_n=0 at step 4 -> no done, product=0, in_ready=1; next 0x02*0x03 -> 0x0006.
REQ-034 start held high for 3 operations -> accepts spaced exactly 10 cycles apart, each product correct.

Source files
------------

// File: rtl/mult8_pkg.sv
// Shared types and constants for the sequential shift-add multiplier.
package mult8_pkg;

  // Operand width used when the parent does not override it.
  localparam int unsigned DefaultWidth = 8;

  // Multiplier control states.
  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRun  = 2'd1,
    StDone = 2'd2
  } state_e;

endpackage

// File: rtl/full_adder.sv
// Single-bit full adder cell.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);

  assign sum  = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/mult8_step_add.sv
// Combinational WIDTH-bit ripple adder for one shift-add step; carry-in is 0,
// carry-out is kept so the step never loses a bit.
module mult8_step_add #(
  parameter int unsigned WIDTH = 8
) (
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  logic [WIDTH:0] carry;

  assign carry[0] = 1'b0;

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    full_adder u_fa (
      .a   (x[i]),
      .b   (y[i]),
      .cin (carry[i]),
      .sum (sum[i]),
      .cout(carry[i+1])
    );
  end

  assign cout = carry[WIDTH];

endmodule

// File: rtl/mult8_seq.sv
// Sequential unsigned multiplier: one shift-add step per cycle, WIDTH steps
// per product, start/in_ready handshake and a one-cycle done pulse.
// Optional feature macro: MULT8_SEQ_ZERO_SKIP_EN (zero operand finishes after
// a single cycle with product 0).
module mult8_seq
  import mult8_pkg::*;
#(
  parameter int unsigned WIDTH = DefaultWidth
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               in_ready,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);

  localparam int unsigned CntW = $clog2(WIDTH) + 1;

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   m_q, m_d;
  logic [2*WIDTH-1:0] p_q, p_d;
  logic [2*WIDTH-1:0] product_q, product_d;
  logic [CntW-1:0]    cnt_q, cnt_d;

  logic [WIDTH-1:0]   addend;
  logic [WIDTH-1:0]   step_sum;
  logic               step_carry;
  logic [2*WIDTH-1:0] p_step;
  logic               last_step;

`ifdef MULT8_SEQ_ZERO_SKIP_EN
  logic skip_q, skip_d;
`endif

  assign addend    = p_q[0] ? m_q : '0;
  assign p_step    = {step_carry, step_sum, p_q[WIDTH-1:1]};
  assign last_step = (cnt_q == CntW'(WIDTH - 1));

  mult8_step_add #(
    .WIDTH(WIDTH)
  ) u_step_add (
    .x   (p_q[2*WIDTH-1:WIDTH]),
    .y   (addend),
    .sum (step_sum),
    .cout(step_carry)
  );

  // Next-state, datapath updates and status outputs.
  always_comb begin
    state_d   = state_q;
    m_d       = m_q;
    p_d       = p_q;
    cnt_d     = cnt_q;
    product_d = product_q;
    in_ready  = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
`ifdef MULT8_SEQ_ZERO_SKIP_EN
    skip_d    = skip_q;
`endif
    unique case (state_q)
      StIdle: begin
        in_ready = 1'b1;
        if (start) begin
          m_d     = a;
          p_d     = {{WIDTH{1'b0}}, b};
          cnt_d   = '0;
          state_d = StRun;
`ifdef MULT8_SEQ_ZERO_SKIP_EN
          skip_d  = (a == '0) || (b == '0);
`endif
        end
      end
      StRun: begin
        busy = 1'b1;
`ifdef MULT8_SEQ_ZERO_SKIP_EN
        if (skip_q) begin
          product_d = '0;
          state_d   = StDone;
        end else
`endif
        begin
          p_d   = p_step;
          cnt_d = cnt_q + CntW'(1);
          if (last_step) begin
            product_d = p_step;
            state_d   = StDone;
          end
        end
      end
      StDone: begin
        done    = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      m_q       <= '0;
      p_q       <= '0;
      cnt_q     <= '0;
      product_q <= '0;
`ifdef MULT8_SEQ_ZERO_SKIP_EN
      skip_q    <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      m_q       <= m_d;
      p_q       <= p_d;
      cnt_q     <= cnt_d;
      product_q <= product_d;
`ifdef MULT8_SEQ_ZERO_SKIP_EN
      skip_q    <= skip_d;
`endif
    end
  end

  assign product = product_q;

endmodule

// File: tb/tb_mult8_seq.sv
// Self-checking bench for mult8_seq at WIDTH=8: table of directed vectors
// plus hand-written mid-run start, reset-abort and back-to-back sequences.
module tb_mult8_seq;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [7:0]  a;
  logic [7:0]  b;
  logic        in_ready;
  logic        busy;
  logic        done;
  logic [15:0] product;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

`ifdef MULT8_SEQ_ZERO_SKIP_EN
  localparam bit ZeroSkip = 1'b1;
`else
  localparam bit ZeroSkip = 1'b0;
`endif

  typedef struct {
    logic [7:0]  a;
    logic [7:0]  b;
    logic [15:0] prod;
  } vec_t;

  vec_t vecs[10];

  mult8_seq #(
    .WIDTH(8)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .a       (a),
    .b       (b),
    .in_ready(in_ready),
    .busy    (busy),
    .done    (done),
    .product (product)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Caller is at a negedge. Runs one multiply; optionally pulses start with
  // junk operands mid-run at sample index mid_at (-1 = never).
  task automatic run_op(input string name, input logic [7:0] va, input logic [7:0] vb,
                        input logic [15:0] exp_prod, input int mid_at);
    int w;
    int lat;
    int nbusy;
    int nready;
    int nchg;
    int exp_lat;
    logic [15:0] prod0;
    w = 0;
    while (!in_ready && w < 30) begin
      @(negedge clk);
      w++;
    end
    check({name, "_ready_wait"}, {31'd0, in_ready}, 32'd1);
    exp_lat = (ZeroSkip && (va == 8'd0 || vb == 8'd0)) ? 1 : 8;
    a = va;
    b = vb;
    start = 1'b1;
    prod0 = product;
    @(negedge clk);
    start = 1'b0;
    lat = 0;
    nbusy = 0;
    nready = 0;
    nchg = 0;
    while (!done && lat < 20) begin
      if (busy) nbusy++;
      if (in_ready) nready++;
      if (product !== prod0) nchg++;
      if (lat == mid_at) begin
        a = 8'hAA;
        b = 8'hAA;
        start = 1'b1;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      lat++;
    end
    start = 1'b0;
    check({name, "_latency"}, lat, exp_lat);
    check({name, "_busy_cycles"}, nbusy, exp_lat);
    check({name, "_ready_in_run"}, nready, 0);
    check({name, "_product_hold"}, nchg, 0);
    check({name, "_product"}, {16'd0, product}, {16'd0, exp_prod});
    @(negedge clk);
    check({name, "_done_width"}, {31'd0, done}, 32'd0);
    check({name, "_ready_after"}, {30'd0, in_ready, busy}, 32'd2);
    check({name, "_product_kept"}, {16'd0, product}, {16'd0, exp_prod});
  endtask

  initial begin
    int ndone;
    int i;
    int j;
    int t;
    int acc[3];
    logic [7:0]  bb_a[3];
    logic [7:0]  bb_b[3];
    logic [15:0] bb_p[3];

    vecs[0] = '{8'hFF, 8'hFF, 16'hFE01};
    vecs[1] = '{8'h0D, 8'h0B, 16'h008F};
    vecs[2] = '{8'h80, 8'h02, 16'h0100};
    vecs[3] = '{8'h00, 8'h37, 16'h0000};
    vecs[4] = '{8'h37, 8'h00, 16'h0000};
    vecs[5] = '{8'h00, 8'h00, 16'h0000};
    vecs[6] = '{8'h01, 8'h01, 16'h0001};
    vecs[7] = '{8'hFF, 8'h01, 16'h00FF};
    vecs[8] = '{8'hC8, 8'h64, 16'h4E20};
    vecs[9] = '{8'h10, 8'h10, 16'h0100};

    bb_a[0] = 8'h07; bb_b[0] = 8'h09; bb_p[0] = 16'h003F;
    bb_a[1] = 8'hFF; bb_b[1] = 8'hFE; bb_p[1] = 16'hFD02;
    bb_a[2] = 8'h12; bb_b[2] = 8'h34; bb_p[2] = 16'h03A8;

    rst_n = 1'b0;
    start = 1'b0;
    a = '0;
    b = '0;
    repeat (2) @(negedge clk);
    check("reset_ready", {31'd0, in_ready}, 32'd1);
    check("reset_busy", {31'd0, busy}, 32'd0);
    check("reset_done", {31'd0, done}, 32'd0);
    check("reset_product", {16'd0, product}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    for (int k = 0; k < 10; k++) begin
      run_op($sformatf("vec%0d", k), vecs[k].a, vecs[k].b, vecs[k].prod, -1);
    end

    // Start pulse with other operands while running must be ignored.
    run_op("mid_start", 8'h03, 8'h05, 16'h000F, 3);
    repeat (3) @(negedge clk);
    check("mid_start_no_accept", {31'd0, busy}, 32'd0);

    // Reset in the middle of a run aborts it with no done pulse.
    a = 8'hFF;
    b = 8'h02;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    check("abort_busy_before", {31'd0, busy}, 32'd1);
    rst_n = 1'b0;
    start = 1'b1;
    @(negedge clk);
    check("abort_ready", {31'd0, in_ready}, 32'd1);
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_done", {31'd0, done}, 32'd0);
    check("abort_product", {16'd0, product}, 32'd0);
    @(negedge clk);
    check("reset_start_ignored", {30'd0, in_ready, busy}, 32'd2);
    rst_n = 1'b1;
    start = 1'b0;
    ndone = 0;
    repeat (12) begin
      @(negedge clk);
      if (done) ndone++;
    end
    check("abort_no_done", ndone, 0);
    run_op("after_abort", 8'h02, 8'h03, 16'h0006, -1);

    // Start held high: accepts every WIDTH+2 cycles.
    i = 0;
    j = 0;
    t = 0;
    start = 1'b1;
    while (j < 3 && t < 100) begin
      if (i == 3) start = 1'b0;
      if (done) begin
        check($sformatf("b2b_product%0d", j), {16'd0, product}, {16'd0, bb_p[j]});
        j++;
      end
      if (in_ready && i < 3) begin
        a = bb_a[i];
        b = bb_b[i];
        acc[i] = cyc;
        i++;
      end
      @(negedge clk);
      t++;
    end
    start = 1'b0;
    check("b2b_completed", j, 3);
    check("b2b_spacing01", acc[1] - acc[0], 10);
    check("b2b_spacing12", acc[2] - acc[1], 10);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
